// File: rtl/sisc_mux_pkg.sv
// Shared definitions for the SISC registered operand selector.
package sisc_mux_pkg;

    localparam logic [1:0] MODE_SELECT = 2'd0;
    localparam logic [1:0] MODE_HOLD   = 2'd1;
    localparam logic [1:0] MODE_SWAP   = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_SWAP2
    } state_e;

endpackage

// File: rtl/mux_sel_comb.sv
// Combinational indexed word pick; out-of-range indices yield zero and raise illegal.
module mux_sel_comb #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        idx,
    output logic [WIDTH-1:0]        word,
    output logic                    illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (idx == SEL_W'(k)) begin
                word    = in_bus[k*WIDTH +: WIDTH];
                illegal = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_sel_pipe.sv
// Registered N-way operand selector with SELECT / HOLD / two-beat SWAP modes and
// valid/ready on both sides.
module mux_sel_pipe
    import sisc_mux_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_f,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic [SEL_W-1:0]        swap_idx,
    input  logic [1:0]              mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_err_q, out_err_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_err_q, pend_err_d;

    logic [WIDTH-1:0] sel_word, swp_word;
    logic             sel_ill, swp_ill;
    logic             accept;

    mux_sel_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_pick_sel (
        .in_bus  (in_bus),
        .idx     (sel),
        .word    (sel_word),
        .illegal (sel_ill)
    );

    mux_sel_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_pick_swp (
        .in_bus  (in_bus),
        .idx     (swap_idx),
        .word    (swp_word),
        .illegal (swp_ill)
    );

    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_err_d   = out_err_q;
        last_d      = last_q;
        pend_d      = pend_q;
        pend_err_d  = pend_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    unique case (mode)
                        MODE_SELECT: begin
                            out_data_d = sel_word;
                            out_err_d  = sel_ill;
                            // An illegal pick must not disturb what HOLD replays.
                            if (!sel_ill) begin
                                last_d = sel_word;
                            end
                        end
                        MODE_HOLD: begin
                            out_data_d = last_q;
                            out_err_d  = 1'b0;
                        end
                        MODE_SWAP: begin
                            out_data_d = sel_word;
                            out_err_d  = sel_ill;
                            pend_d     = swp_word;
                            pend_err_d = swp_ill;
                            state_d    = ST_SWAP2;
                        end
                        default: begin
                            out_data_d = last_q;
                            out_err_d  = 1'b1;
                        end
                    endcase
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            ST_SWAP2: begin
                // Second beat comes from the word captured at acceptance, not the live bus.
                if (out_ready) begin
                    out_data_d = pend_q;
                    out_err_d  = pend_err_q;
                    last_d     = pend_q;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_q     <= ST_IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            last_q      <= '0;
            pend_q      <= '0;
            pend_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
            last_q      <= last_d;
            pend_q      <= pend_d;
            pend_err_q  <= pend_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_err   = out_err_q;

endmodule

// File: doc/mux_sel_pipe.md
Name: mux_sel_pipe

Overview:
- Parametrised, registered N-way operand selector for the SISC datapath. It replaces fixed-width combinational muxes whose unassigned selects infer latches.
- Each accepted beat selects one of NUM_IN words. Modes: plain select, explicit hold of the last output, and a two-beat swap sequence.
- Valid/ready on both sides, so it can sit between the register file read stage and the ALU operand latch.

Parameters:
- WIDTH, 16, data width of each input and the output
- NUM_IN, 4, number of input words (2..16)
- SEL_W, $clog2(NUM_IN), width of sel and swap_idx

Ports:
- clk  in  1  rising-edge clock
- rst_f  in  1  synchronous, active-low reset
- in_bus  in  NUM_IN*WIDTH  packed inputs; word k = in_bus[k*WIDTH +: WIDTH]
- sel  in  SEL_W  primary input index
- swap_idx  in  SEL_W  secondary index, used in SWAP mode only
- mode  in  2  0=SELECT, 1=HOLD, 2=SWAP, 3=reserved
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&&in_ready
- out_data  out  WIDTH  registered selected word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts when out_valid&&out_ready
- out_err  out  1  qualified by out_valid; beat came from an illegal index or mode

Behaviour:
- Reset (rst_f=0 at posedge), dominates all other inputs, aborts any sequence in flight:
  - out_data=0, out_valid=0, out_err=0, state=IDLE, last-value register=0.
- Output stage: single register; latency is 1 cycle from acceptance to out_valid.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Combinational; must not depend on in_valid.
- Output hold: out_data, out_valid and out_err are stable while out_valid && !out_ready.
- Accepting a beat in IDLE:
  - SELECT: out_data <= word[sel]. The last-value register is updated with the same word.
  - HOLD: out_data <= last-value register, which is unchanged. A HOLD straight after reset emits 0.
  - SWAP: out_data <= word[sel]. Capture word[swap_idx] into a pending register; state <= SWAP2.
  - mode 3: behaves as HOLD, with out_err=1.
- Illegal index: sel (or swap_idx in SWAP) >= NUM_IN.
  - The corresponding word is 0 and out_err=1 on that beat.
  - The last-value register is not updated by an illegal SELECT.
- State SWAP2:
  - in_ready=0.
  - When the first beat is consumed (out_ready), out_data <= pending and out_valid stays 1.
  - out_err = illegal swap_idx; the last-value register <= pending; state <= IDLE.
  - Inputs are ignored; the pending word is the one captured at acceptance, not re-sampled.
- Simultaneous consume and accept in IDLE: the new beat loads the same cycle, so out_valid stays 1 with no bubble.
- No accept and out_ready=1: out_valid <= 0.
- Throughput: 1 beat/cycle in SELECT and HOLD; SWAP occupies 2 output cycles.

Decomposition:
- Shared package sisc_mux_pkg holds:
  - mode localparams MODE_SELECT=2'd0, MODE_HOLD=2'd1, MODE_SWAP=2'd2, MODE_RSVD=2'd3
  - FSM state encoding ST_IDLE, ST_SWAP2
- One sub-module: mux_sel_comb. It is a purely combinational indexed word pick with an out-of-range flag, instantiated twice (sel, swap_idx).

Test Plan:
- Reset and SELECT: rst_f low 2 cycles → out_valid=0, out_data=0. Then WIDTH=16, NUM_IN=4, words {0x1111,0x2222,0x3333,0x4444}, SELECT sel=2 accepted → next cycle out_data=0x3333, out_valid=1, out_err=0.
- Back-pressure and streaming:
  - out_ready=0 for 3 cycles with out_valid=1 → out_data stable and in_ready=0.
  - Then a continuous SELECT stream sel=0,1,3 with out_ready=1 → outputs 0x1111,0x2222,0x4444 on consecutive cycles.
- HOLD: SELECT sel=1 then HOLD → outputs 0x2222, 0x2222. Change in_bus before the HOLD → output still 0x2222. HOLD right after reset → 0x0000.
- SWAP: sel=0, swap_idx=3 → outputs 0x1111 then 0x4444, with in_ready=0 during the second beat. Hold out_ready low 2 cycles mid-sequence → second beat delayed, value unchanged; a following HOLD emits 0x4444.
- Errors:
  - NUM_IN=3, SELECT sel=3 → out_data=0, out_err=1, and a later HOLD returns the prior legal value.
  - mode=3 → HOLD value with out_err=1.
- Reset mid-SWAP: rst_f low during SWAP2 → next cycle out_valid=0, state IDLE, in_ready=1, and no pending beat is emitted.
